fmul_share_ctrl: RTL and testbench



---
 rtl/fmul_share_pkg.sv | 38 +++
 rtl/fmul_share_ctrl_rr_arb.sv | 56 +++++
 rtl/fmul_share_ctrl.sv | 151 +++++++++++++++
 tb/tb_fmul_share_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_share_pkg.sv
// fmul_share_pkg
//   Shared types and constants for the fmul_share_ctrl block: FSM state
//   encoding, the operand-pair struct carried from the requester mux into
//   the core operand registers, and FP32 field helpers used by the optional
//   result-class flags (FMUL_SHARE_FLAGS_EN).
package fmul_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One operand pair as presented to the multiplier core.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } fmul_op_t;

  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP32_QNAN    = 32'hFFC0_0000;  // NaN pattern the core emits

  // FP32 field layout.
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_MAN_W    = 23;

  function automatic logic [FP32_EXP_W-1:0] fp32_exp(input logic [31:0] v);
    return v[FP32_EXP_LSB +: FP32_EXP_W];
  endfunction

  function automatic logic [FP32_MAN_W-1:0] fp32_man(input logic [31:0] v);
    return v[FP32_MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fmul_share_ctrl_rr_arb.sv
// rr_arb
//   Round-robin arbiter. Produces a one-hot grant for the first requester
//   with req set, searching upward from ptr with wrap-around. The grant is
//   purely combinational; ptr moves to the slot after the winner only when
//   the grant is actually taken.
// Ports:
//   clk, rst        clock, synchronous active-high reset (ptr -> 0)
//   req[NREQ]       request vector
//   en              grant enable (low forces gnt to zero)
//   take            the current grant was accepted this cycle
//   gnt[NREQ]       one-hot grant (or zero)
//   gnt_idx         binary index of the granted requester
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  input  logic                    take,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr;
  logic          found;
  int            idx;

  // Walk NREQ slots starting at ptr; first hit wins. idx wraps by a single
  // subtraction since ptr + k < 2*NREQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fmul_share_ctrl.sv
// fmul_share_ctrl
//   Shares one fixed-latency FP32 multiplier core among NREQ requesters.
//   IDLE grants one requester round-robin and latches its operands; START
//   pulses mul_rst to restart the core; RUN waits MUL_LAT cycles and
//   captures mul_z; DONE presents the product until rsp_ready. Exactly one
//   operation is in flight at a time.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (req_ready one-hot or 0)
//   req_a, req_b             per-requester operands, slice [32*i +: 32]
//   rsp_valid/rsp_ready      response handshake
//   rsp_z, rsp_id            product and issuing requester index
//   rsp_nan/inf/zero         result class flags (only with FMUL_SHARE_FLAGS_EN)
//   mul_rst                  core phase restart, also high during rst
//   mul_a, mul_b             registered core operands
//   mul_z                    core result
// Config macro: FMUL_SHARE_FLAGS_EN adds the rsp_nan/rsp_inf/rsp_zero outputs.
module fmul_share_ctrl
  import fmul_share_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [32*NREQ-1:0]      req_a,
  input  logic [32*NREQ-1:0]      req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_z,
  output logic [$clog2(NREQ)-1:0] rsp_id,
`ifdef FMUL_SHARE_FLAGS_EN
  output logic                    rsp_nan,
  output logic                    rsp_inf,
  output logic                    rsp_zero,
`endif
  output logic                    mul_rst,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  input  logic [31:0]             mul_z
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MUL_LAT + 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          arb_en;
  logic          hs;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] id_q;
  fmul_op_t      op_sel, op_q;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (arb_en),
    .take    (hs),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  assign hs       = |(req_valid & req_ready);
  assign cnt_last = (cnt == CW'(MUL_LAT - 1));

  always_comb begin
    op_sel.a = req_a[32*gnt_idx +: 32];
    op_sel.b = req_b[32*gnt_idx +: 32];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (hs) nxt = START;
      START:   nxt = RUN;
      RUN:     if (cnt_last) nxt = DONE;
      DONE:    if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs. rst is folded in so the core is held in restart and nothing is
  // granted or presented while reset is asserted, whatever state it hit.
  always_comb begin
    mul_rst   = rst | (state == START);
    rsp_valid = ~rst & (state == DONE);
    arb_en    = ~rst & (state == IDLE);
  end

  // Wait counter: cleared in START, so in RUN it reads 0..MUL_LAT-1 and the
  // last RUN cycle is the one where mul_z has settled.
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (state == START) cnt <= '0;
    else if (state == RUN)   cnt <= cnt + 1'b1;
  end

  // Operand/ID capture at the grant; held until the next grant so the core
  // sees stable inputs for the whole operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      id_q <= '0;
    end else if (hs) begin
      op_q <= op_sel;
      id_q <= gnt_idx;
    end
  end

  assign mul_a  = op_q.a;
  assign mul_b  = op_q.b;
  assign rsp_id = id_q;

  // Result capture on the final RUN cycle; stays put through DONE.
  always_ff @(posedge clk) begin
    if (rst)                            rsp_z <= '0;
    else if ((state == RUN) && cnt_last) rsp_z <= mul_z;
  end

`ifdef FMUL_SHARE_FLAGS_EN
  logic exp_max, exp_zero, man_zero;
  always_comb begin
    exp_max  = (fp32_exp(mul_z) == FP32_EXP_MAX);
    exp_zero = (fp32_exp(mul_z) == '0);
    man_zero = (fp32_man(mul_z) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_nan  <= 1'b0;
      rsp_inf  <= 1'b0;
      rsp_zero <= 1'b0;
    end else if ((state == RUN) && cnt_last) begin
      rsp_nan  <= exp_max & ~man_zero;
      rsp_inf  <= exp_max & man_zero;
      rsp_zero <= exp_zero & man_zero;
    end
  end
`endif

endmodule

// File: tb/tb_fmul_share_ctrl.sv
module tb_fmul_share_ctrl;
  import fmul_share_pkg::*;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 8;
  localparam int LAT     = MUL_LAT + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [32*NREQ-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_z;
  logic [1:0]        rsp_id;
`ifdef FMUL_SHARE_FLAGS_EN
  logic              rsp_nan, rsp_inf, rsp_zero;
`endif
  logic              mul_rst;
  logic [31:0]       mul_a, mul_b, mul_z;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 0;

  always #5 clk = ~clk;

  fmul_share_ctrl #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_id(rsp_id),
`ifdef FMUL_SHARE_FLAGS_EN
    .rsp_nan(rsp_nan), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
`endif
    .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z)
  );

  // Core model: known products only, valid solely in the cycle the
  // controller is expected to sample; garbage otherwise.
  function automatic logic [31:0] core_prod(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3FC00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h40400000}: return 32'h40400000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h40400000, 32'h40400000}: return 32'h41100000;
      {32'h7F800000, 32'h00000000}: return FP32_QNAN;
      {32'h7F800000, 32'h3F800000}: return 32'h7F800000;
      {32'h00000000, 32'h40000000}: return 32'h00000000;
      {32'hBF800000, 32'h40000000}: return 32'hC0000000;
      default:                      return 32'h0BAD0BAD;
    endcase
  endfunction

  logic [3:0] core_cnt;
  always @(posedge clk) begin
    if (mul_rst)              core_cnt <= 4'd0;
    else if (core_cnt != 4'hF) core_cnt <= core_cnt + 4'd1;
  end
  assign mul_z = (core_cnt == 4'(MUL_LAT - 1)) ? core_prod(mul_a, mul_b) : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous grant-shape checks and requester protocol watch.
  logic [NREQ-1:0] pend_q = '0;
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (rsp_valid) chk("ready_zero_in_done", 32'(req_ready), 32'd0);
      for (int i = 0; i < NREQ; i++)
        if (pend_q[i] && !req_valid[i])
          $display("protocol error: requester %0d withdrew request before grant", i);
    end
    pend_q <= rst ? '0 : (req_valid & ~req_ready);
  end

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid[id]      = 1'b1;
  endtask

  // Returns at the negedge where a handshake is pending (it completes at the
  // next posedge). waits = number of negedges observed, gid = -1 on timeout.
  task automatic wait_grant(output int gid, output int waits);
    gid = -1;
    waits = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        waits = c;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        break;
      end
    end
  endtask

  // Called at cycle 1 start; returns at the negedge where rsp_valid is first
  // seen. lat counts cycles after the grant handshake, -1 on timeout.
  task automatic wait_rsp(output int lat, output logic mrst1);
    lat = -1;
    mrst1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) mrst1 = mul_rst;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic pass_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    logic [31:0] a, b, z;
    logic        nan, inf, zero;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int gid, waits, lat, seen;
    logic mrst1;
    int rr_exp[5];

    vecs[0] = '{2, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1, 32'h7F800000, 32'h00000000, 32'hFFC00000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{3, 32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{0, 32'hBF800000, 32'h40000000, 32'hC0000000, 1'b0, 1'b0, 1'b0};
    rr_exp  = '{0, 1, 2, 3, 0};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

    // ---- reset state
    repeat (2) @(negedge clk);
    chk("rst_mul_rst_high", 32'(mul_rst), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    pass_edge();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_mul_rst", 32'(mul_rst), 32'd0);
    chk("post_rst_rsp_z", rsp_z, 32'd0);
    chk("post_rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("post_rst_mul_a", mul_a, 32'd0);
    chk("post_rst_mul_b", mul_b, 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd0);
`ifdef FMUL_SHARE_FLAGS_EN
    chk("post_rst_flags", 32'({rsp_nan, rsp_inf, rsp_zero}), 32'd0);
`endif
    mon_en = 1'b1;

    // ---- table-driven single requests
    for (int v = 0; v < 5; v++) begin
      pass_edge();
      set_req(vecs[v].id, vecs[v].a, vecs[v].b);
      wait_grant(gid, waits);
      chk("vec_grant_id", 32'(gid), 32'(vecs[v].id));
      pass_edge();
      if (gid >= 0) req_valid[gid] = 1'b0;
      wait_rsp(lat, mrst1);
      chk("vec_latency", 32'(lat), 32'(LAT));
      chk("vec_mul_rst_start", 32'(mrst1), 32'd1);
      chk("vec_mul_a_held", mul_a, vecs[v].a);
      chk("vec_mul_b_held", mul_b, vecs[v].b);
      chk("vec_rsp_z", rsp_z, vecs[v].z);
      chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
`ifdef FMUL_SHARE_FLAGS_EN
      chk("vec_flags", 32'({rsp_nan, rsp_inf, rsp_zero}),
          32'({vecs[v].nan, vecs[v].inf, vecs[v].zero}));
`endif
      pass_edge();
      @(negedge clk);
      chk("vec_rsp_valid_drop", 32'(rsp_valid), 32'd0);
    end

    // ---- only requester 3 valid with ptr=0: granted immediately
    pass_edge(); rst = 1'b1;
    pass_edge(); rst = 1'b0;
    set_req(3, 32'h40000000, 32'h40000000);
    wait_grant(gid, waits);
    chk("r3_grant_id", 32'(gid), 32'd3);
    chk("r3_no_idle", 32'(waits), 32'd1);
    pass_edge();
    req_valid[3] = 1'b0;
    wait_rsp(lat, mrst1);
    chk("r3_rsp_z", rsp_z, 32'h40800000);
    chk("r3_rsp_id", 32'(rsp_id), 32'd3);
    pass_edge();

    // ---- all four valid: round robin 0,1,2,3,0 (ptr wrapped after 3)
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h3F800000, 32'h40400000);
    for (int k = 0; k < 5; k++) begin
      wait_grant(gid, waits);
      chk("rr_grant_order", 32'(gid), 32'(rr_exp[k]));
      chk("rr_back_to_back", 32'(waits), 32'd1);
      pass_edge();
      if (k == 4) req_valid = '0;
      wait_rsp(lat, mrst1);
      chk("rr_latency", 32'(lat), 32'(LAT));
      chk("rr_rsp_id", 32'(rsp_id), 32'(rr_exp[k]));
      chk("rr_rsp_z", rsp_z, 32'h40400000);
      pass_edge();
    end

    // ---- response backpressure for 20 cycles (ptr=1 here)
    rsp_ready = 1'b0;
    set_req(1, 32'h40000000, 32'h40000000);
    wait_grant(gid, waits);
    chk("bp_grant_id", 32'(gid), 32'd1);
    pass_edge();
    req_valid[1] = 1'b0;
    set_req(0, 32'h40400000, 32'h40400000);
    set_req(3, 32'h3FC00000, 32'h40000000);
    wait_rsp(lat, mrst1);
    chk("bp_latency", 32'(lat), 32'(LAT));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_z_held", rsp_z, 32'h40800000);
      chk("bp_id_held", 32'(rsp_id), 32'd1);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    pass_edge();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_until_ready_edge", 32'(rsp_valid), 32'd1);
    pass_edge();
    // ptr=2 with 0 and 3 pending: 3 wins, then 0
    wait_grant(gid, waits);
    chk("bp_next_grant", 32'(gid), 32'd3);
    chk("bp_next_no_idle", 32'(waits), 32'd1);
    pass_edge();
    req_valid[3] = 1'b0;
    wait_rsp(lat, mrst1);
    chk("bp_r3_z", rsp_z, 32'h40400000);
    chk("bp_r3_id", 32'(rsp_id), 32'd3);
    pass_edge();
    wait_grant(gid, waits);
    chk("bp_r0_grant", 32'(gid), 32'd0);
    pass_edge();
    req_valid[0] = 1'b0;
    wait_rsp(lat, mrst1);
    chk("bp_r0_z", rsp_z, 32'h41100000);
    chk("bp_r0_id", 32'(rsp_id), 32'd0);
    pass_edge();

    // ---- reset during RUN (grant 2 moves ptr to 3)
    set_req(2, 32'h3FC00000, 32'h40000000);
    wait_grant(gid, waits);
    chk("mr_grant_id", 32'(gid), 32'd2);
    pass_edge();
    req_valid[2] = 1'b0;
    repeat (4) @(negedge clk);
    pass_edge();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_mul_rst_in_rst", 32'(mul_rst), 32'd1);
    chk("mr_rsp_valid_in_rst", 32'(rsp_valid), 32'd0);
    pass_edge();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rsp_z", rsp_z, 32'd0);
    chk("mr_rsp_id", 32'(rsp_id), 32'd0);
    chk("mr_mul_a", mul_a, 32'd0);
    chk("mr_mul_b", mul_b, 32'd0);
    chk("mr_mul_rst", 32'(mul_rst), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mr_no_abandoned_rsp", 32'(seen), 32'd0);
    // 2 and 3 both valid: ptr back at 0 selects 2 (a stale ptr=3 would pick 3)
    pass_edge();
    set_req(2, 32'h3FC00000, 32'h40000000);
    set_req(3, 32'h40000000, 32'h40000000);
    wait_grant(gid, waits);
    chk("mr_reissue_grant", 32'(gid), 32'd2);
    pass_edge();
    req_valid[2] = 1'b0;
    wait_rsp(lat, mrst1);
    chk("mr_reissue_latency", 32'(lat), 32'(LAT));
    chk("mr_reissue_z", rsp_z, 32'h40400000);
    chk("mr_reissue_id", 32'(rsp_id), 32'd2);
    pass_edge();
    wait_grant(gid, waits);
    chk("mr_r3_grant", 32'(gid), 32'd3);
    pass_edge();
    req_valid[3] = 1'b0;
    wait_rsp(lat, mrst1);
    chk("mr_r3_z", rsp_z, 32'h40800000);
    chk("mr_r3_id", 32'(rsp_id), 32'd3);
    pass_edge();

    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
